// File: rtl/echo_pkg.sv
// Shared definitions for the echo block and its downstream indication queue.
package echo_pkg;

  localparam int ECHO_WIDTH = 32;

  typedef logic [ECHO_WIDTH-1:0] echo_payload_t;

  // Pointer width: index bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/queue_storage_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module queue_storage_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/echo_indication_queue.sv
// In-order queue sinking the echo block's heard indication; tracks occupancy,
// accepted-enqueue total and a sticky protocol-error flag.
module echo_indication_queue
  import echo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ECHO_WIDTH
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   heard__ENA,
  input  logic [WIDTH-1:0]       heard_v,
  output logic                   heard__RDY,
  input  logic                   drain__ENA,
  output logic [WIDTH-1:0]       drain_v,
  output logic                   drain__RDY,
  output logic [$clog2(DEPTH):0] count,
  output logic [31:0]            heard_total,
  output logic                   err
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [31:0]   total_q, total_d;
  logic          err_q, err_d;
  logic          empty, full, enq, deq;

  assign empty = (head_q == tail_q);
  assign full  = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);

  // Ready flags come only from registered pointers, never from the strobes.
  assign heard__RDY = !full;
  assign drain__RDY = !empty;

  assign enq = heard__ENA && !full;
  assign deq = drain__ENA && !empty;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    total_d = total_q;
    err_d   = err_q | (heard__ENA && full) | (drain__ENA && empty);
    if (enq) begin
      tail_d  = tail_q + PW'(1);
      total_d = total_q + 32'd1;
    end
    if (deq) begin
      head_d = head_q + PW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      total_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      total_q <= total_d;
      err_q   <= err_d;
    end
  end

  queue_storage_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_storage (
    .clk_i   (CLK),
    .we_i    (enq && !RST),
    .waddr_i (tail_q[AW-1:0]),
    .wdata_i (heard_v),
    .raddr_i (head_q[AW-1:0]),
    .rdata_o (drain_v)
  );

  assign count       = tail_q - head_q;
  assign heard_total = total_q;
  assign err         = err_q;

endmodule

// File: tb/tb_echo_indication_queue.sv
// Bench for echo_indication_queue: queue-based reference model, directed plan, random traffic.
module tb_echo_indication_queue;
  import echo_pkg::*;

  localparam int DEPTH = 4;

  logic                   CLK = 1'b0;
  logic                   RST = 1'b1;
  logic                   heard__ENA = 1'b0;
  echo_payload_t          heard_v = '0;
  logic                   heard__RDY;
  logic                   drain__ENA = 1'b0;
  echo_payload_t          drain_v;
  logic                   drain__RDY;
  logic [$clog2(DEPTH):0] count;
  logic [31:0]            heard_total;
  logic                   err;

  echo_indication_queue #(.DEPTH(DEPTH), .WIDTH(ECHO_WIDTH)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .heard__ENA  (heard__ENA),
    .heard_v     (heard_v),
    .heard__RDY  (heard__RDY),
    .drain__ENA  (drain__ENA),
    .drain_v     (drain_v),
    .drain__RDY  (drain__RDY),
    .count       (count),
    .heard_total (heard_total),
    .err         (err)
  );

  always #5 CLK = ~CLK;

  // Reference model
  logic [31:0] m_q[$];
  logic [31:0] m_total = 0;
  logic        m_err = 1'b0;
  bit          chk_en = 1'b0;

  int nvec = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic he, input logic [31:0] hv, input logic de, input logic r);
    bit can_enq, can_deq;
    if (r) begin
      m_q.delete();
      m_total = 0;
      m_err   = 1'b0;
    end else begin
      can_enq = (m_q.size() < DEPTH);
      can_deq = (m_q.size() > 0);
      if (he && !can_enq) m_err = 1'b1;
      if (de && !can_deq) m_err = 1'b1;
      if (de && can_deq) void'(m_q.pop_front());
      if (he && can_enq) begin
        m_q.push_back(hv);
        m_total = m_total + 32'd1;
      end
    end
  endtask

  // Drive inputs from the falling edge, apply one rising edge, return at the next falling edge.
  task automatic step(input logic he, input logic [31:0] hv, input logic de, input logic r);
    heard__ENA = he;
    heard_v    = hv;
    drain__ENA = de;
    RST        = r;
    @(posedge CLK);
    model_edge(he, hv, de, r);
    @(negedge CLK);
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("heard_rdy", 64'(heard__RDY), 64'(m_q.size() < DEPTH));
      chk("drain_rdy", 64'(drain__RDY), 64'(m_q.size() != 0));
      chk("count", 64'(count), 64'(m_q.size()));
      chk("heard_total", 64'(heard_total), 64'(m_total));
      chk("err", 64'(err), 64'(m_err));
      if (m_q.size() != 0) chk("drain_v", 64'(drain_v), 64'(m_q[0]));
    end
  end

  initial begin
    logic [31:0] exp_v;
    @(negedge CLK);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk_en = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b0);

    // Idle after reset
    chk("rst_hrdy", 64'(heard__RDY), 64'd1);
    chk("rst_drdy", 64'(drain__RDY), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_total", 64'(heard_total), 64'd0);
    chk("rst_err", 64'(err), 64'd0);

    // Fill with 0x11..0x44 then drain in order
    for (int i = 1; i <= 4; i++) step(1'b1, 32'(i * 'h11), 1'b0, 1'b0);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_hrdy", 64'(heard__RDY), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      chk("order_v", 64'(drain_v), 64'(i * 'h11));
      step(1'b0, 32'h0, 1'b1, 1'b0);
    end
    chk("order_total", 64'(heard_total), 64'd4);
    chk("order_empty", 64'(drain__RDY), 64'd0);

    // Overflow attempt while full
    for (int i = 0; i < 4; i++) step(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'hDEAD, 1'b0, 1'b0);
    chk("ovf_err", 64'(err), 64'd1);
    chk("ovf_count", 64'(count), 64'd4);
    chk("ovf_total", 64'(heard_total), 64'd8);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_v", 64'(drain_v), 64'(32'hA0 + 32'(i)));
      step(1'b0, 32'h0, 1'b1, 1'b0);
    end
    chk("ovf_drained", 64'(count), 64'd0);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Sustained simultaneous enqueue/drain at count=2, across pointer wrap
    step(1'b1, 32'd100, 1'b0, 1'b0);
    step(1'b1, 32'd200, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      exp_v = (i == 1) ? 32'd100 : (i == 2) ? 32'd200 : 32'(i - 2);
      chk("sim_v", 64'(drain_v), 64'(exp_v));
      step(1'b1, 32'(i), 1'b1, 1'b0);
      chk("sim_count", 64'(count), 64'd2);
    end
    chk("sim_total", 64'(heard_total), 64'd12);
    chk("sim_tail9", 64'(drain_v), 64'd9);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("sim_tail10", 64'(drain_v), 64'd10);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Underflow
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("udf_err", 64'(err), 64'd1);
    chk("udf_count", 64'(count), 64'd0);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Reset mid-operation with a concurrent enqueue
    for (int i = 0; i < 3; i++) step(1'b1, 32'h50 + 32'(i), 1'b0, 1'b0);
    chk("pre_rst_count", 64'(count), 64'd3);
    step(1'b1, 32'h77, 1'b0, 1'b1);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_drdy", 64'(drain__RDY), 64'd0);
    chk("mid_rst_total", 64'(heard_total), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("post_rst_drdy", 64'(drain__RDY), 64'd0);

    // Random traffic including violations and occasional resets
    for (int c = 0; c < 1500; c++) begin
      step($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 99) == 0);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
